mul_accumulator: RTL and testbench
==================================

// Module: mul_accumulator
// PURPOSE
//   Downstream stage of the 4x4 combinational Multiplier. Consumes its 8-bit products
//   through a valid/ready handshake and sums a programmed number of terms (N) into a wide
//   accumulator. Presents the finished sum to the ALU result path with a second handshake.
//   Used for dot-product / multiply-accumulate ops.
// PARAMETERS
//   PROD_W   8   width of incoming product (Multiplier out)
//   ACC_W    16  accumulator / result width; must be >= PROD_W
//   CNT_W    4   width of term count; N ranges 0..2^CNT_W-1
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous, active-high reset
//   start      in   1        begin a new accumulation; honoured only in IDLE
//   n_terms    in   CNT_W    number of products to sum; sampled when start is honoured
//   in_valid   in   1        product valid
//   in_ready   out  1        stage can accept a product
//   product    in   PROD_W   unsigned product from Multiplier
//   acc_out    out  ACC_W    accumulated sum
//   out_valid  out  1        acc_out is final
//   out_ready  in   1        consumer accepts result
//   overflow   out  1        sticky: some add exceeded ACC_W within this accumulation
//   busy       out  1        state != IDLE
// BEHAVIOUR
//   - Reset (async, any state, including mid-accumulation): state=IDLE, acc=0, cnt=0,
//     overflow=0. All outputs low except acc_out=0. Partial sums are discarded.
//   - FSM IDLE -> ACCUM -> DONE -> IDLE, with state register encoded per the package enum.
//   - IDLE: in_ready=0, out_valid=0. On start: acc<=0, overflow<=0, cnt<=0, latch n_terms.
//     Then go to ACCUM, or directly to DONE if n_terms==0 (result 0).
//   - ACCUM: in_ready=1. A product is accepted on a cycle where in_valid&&in_ready is high:
//     acc<=acc+zero_ext(product), cnt<=cnt+1. Cycles without in_valid hold all state.
//     On the accept where cnt==N-1, go to DONE; that last term is included in acc.
//   - DONE: out_valid=1, in_ready=0, acc stable. On out_ready, go to IDLE on the next cycle.
//     acc_out and overflow hold their values until the next honoured start.
//   - Latency: last accept -> out_valid on the next cycle; start with N=0 -> out_valid on
//     the next cycle.
//   - start outside IDLE is ignored. In the DONE state, start and out_ready in the same
//     cycle -> IDLE only; the start is not honoured.
//   - Arithmetic: unsigned; the adder is ACC_W+1 bits wide; the carry out sets overflow
//     (sticky).
// CONFIGURATION
//   MUL_ACC_SATURATE_EN defined: on carry out, acc is clamped to {ACC_W{1'b1}} and stays
//     clamped for the rest of the accumulation.
//   MUL_ACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W.
//   overflow is flagged identically in both builds.
// STRUCTURE
//   - Package mul_acc_pkg: state enum {IDLE, ACCUM, DONE}, default widths PROD_W/ACC_W/CNT_W,
//     ACC_MAX constant.
//   - One sub-module, acc_adder: combinational ACC_W+1 add, with clamp gated by
//     MUL_ACC_SATURATE_EN. It returns sum and carry.
//   - FSM, counter and registers stay in mul_accumulator.
// TESTING
//   1. start,N=3; products 15,12,225 back-to-back -> out_valid 1 cycle after 3rd,
//      acc_out=252, overflow=0.
//   2. N=3 with in_valid gaps of 2 cycles between terms -> same 252. in_ready=1 throughout
//      ACCUM; cnt holds during gaps.
//   3. ACC_W=8, N=2, products 200,100 -> overflow=1; acc_out=44 without macro, 255 with
//      MUL_ACC_SATURATE_EN.
//   4. start,N=0 -> out_valid next cycle, acc_out=0. Hold out_ready=0 for 5 cycles ->
//      outputs stable, then handshake -> IDLE.
//   5. N=4; assert rst after 2 accepts -> state IDLE, acc_out=0, in_ready=0 immediately
//      (async). A fresh N=1 run with 7 -> 7.
//   6. start pulsed during ACCUM and together with out_ready in DONE -> ignored; the
//      result is unchanged and no new accumulation begins.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// Shared types and default widths for the multiply-accumulate stage.
// The MUL_ACC_SATURATE_EN macro changes only the adder; see acc_adder.
package mul_acc_pkg;

    localparam int PROD_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 4;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mul_accumulator_acc_adder.sv
// Combinational ACC_W+1 bit adder for the accumulator, returning sum and carry.
// With MUL_ACC_SATURATE_EN defined the sum clamps to all-ones on carry, otherwise it wraps.
module acc_adder #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
    assign carry_o  = full_sum[ACC_W];

`ifdef MUL_ACC_SATURATE_EN
    // Once clamped, any further non-zero term carries again, so the clamp persists.
    assign sum_o = full_sum[ACC_W] ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul_accumulator.sv
// Sums a programmed number of Multiplier products and hands the total downstream.
// Build option MUL_ACC_SATURATE_EN selects clamping instead of wrap on overflow.
module mul_accumulator #(
    parameter int PROD_W = mul_acc_pkg::PROD_W,
    parameter int ACC_W  = mul_acc_pkg::ACC_W,
    parameter int CNT_W  = mul_acc_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_terms,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              busy
);

    import mul_acc_pkg::*;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;

    acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc_i   (acc_q),
        .prod_i  (product),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    n_d     = n_terms;
                    state_d = (n_terms == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_carry;
                    cnt_d = cnt_q + CNT_W'(1);
                    // n_q is at least 1 here, so the decrement cannot underflow.
                    if (cnt_q == n_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Randomized and directed bench for mul_accumulator, checked against an arithmetic model.
// Two instances share stimulus: default widths and an 8-bit accumulator for overflow cases.
module tb_mul_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  n_terms;
    logic        in_valid;
    logic [7:0]  product;
    logic        out_ready;

    logic        in_ready, out_valid, overflow, busy;
    logic [15:0] acc_out;
    logic        in_ready8, out_valid8, overflow8, busy8;
    logic [7:0]  acc_out8;

    int n_checks = 0;
    int n_fail   = 0;
    int prods [16];

    mul_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_terms   (n_terms),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    mul_accumulator #(.PROD_W(8), .ACC_W(8), .CNT_W(4)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_terms   (n_terms),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .product   (product),
        .acc_out   (acc_out8),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .overflow  (overflow8),
        .busy      (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain sum of the terms, then wrap or clamp to the accumulator width.
    function automatic void model(input int n, input int w, output longint exp_acc, output bit exp_ovf);
        longint total = 0;
        longint lim;
        lim = longint'(1) << w;
        for (int i = 0; i < n; i++) total += prods[i];
        exp_ovf = (total >= lim);
`ifdef MUL_ACC_SATURATE_EN
        exp_acc = exp_ovf ? lim - 1 : total;
`else
        exp_acc = total % lim;
`endif
    endfunction

    // Starts a run and feeds prods[0..n-1] with a fixed idle gap before each term.
    task automatic drive_terms(input int n, input int gap);
        start   = 1'b1;
        n_terms = 4'(n);
        cyc();
        start   = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (gap) cyc();
            in_valid = 1'b1;
            product  = 8'(prods[i]);
            cyc();
            in_valid = 1'b0;
        end
    endtask

    task automatic finish_handshake();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({busy, in_ready, out_valid, overflow} !== 4'b0 || acc_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b in_ready=%b out_valid=%b ovf=%b acc=%0d, required all 0",
                     busy, in_ready, out_valid, overflow, acc_out);
        end
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        n_checks++;
        if (busy !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b busy8=%b, required 0", busy, busy8);
        end
        $display("reset: busy=%b acc=%0d", busy, acc_out);
    endtask

    task automatic test_back_to_back();
        prods[0] = 15; prods[1] = 12; prods[2] = 225;
        drive_terms(3, 0);
        n_checks++;
        if (out_valid !== 1'b1 || acc_out !== 16'd252 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: out_valid=%b acc=%0d ovf=%b, required 1 252 0",
                     out_valid, acc_out, overflow);
        end
        n_checks++;
        if (acc_out8 !== 8'd252 || overflow8 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result8: acc=%0d ovf=%b, required 252 0", acc_out8, overflow8);
        end
        finish_handshake();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || acc_out !== 16'd252) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b out_valid=%b acc=%0d, required 0 0 252", busy, out_valid, acc_out);
        end
        $display("back_to_back: acc=%0d ovf=%b", acc_out, overflow);
    endtask

    task automatic test_gaps();
        prods[0] = 15; prods[1] = 12; prods[2] = 225;
        start = 1'b1; n_terms = 4'd3;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < 2; g++) begin
                n_checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_ready: term=%0d in_ready=%b out_valid=%b, required 1 0", i, in_ready, out_valid);
                end
                cyc();
            end
            in_valid = 1'b1; product = 8'(prods[i]);
            cyc();
            in_valid = 1'b0;
        end
        n_checks++;
        if (out_valid !== 1'b1 || acc_out !== 16'd252 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_result: out_valid=%b acc=%0d in_ready=%b, required 1 252 0", out_valid, acc_out, in_ready);
        end
        finish_handshake();
        $display("gaps: acc=%0d", acc_out);
    endtask

    task automatic test_overflow();
        longint exp8;
        bit     ov8;
        prods[0] = 200; prods[1] = 100;
        model(2, 8, exp8, ov8);
        drive_terms(2, 0);
        n_checks++;
        if (acc_out8 !== 8'(exp8) || overflow8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf8: acc=%0d ovf=%b, required %0d 1", acc_out8, overflow8, exp8);
        end
        n_checks++;
        if (acc_out !== 16'd300 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf16: acc=%0d ovf=%b, required 300 0", acc_out, overflow);
        end
        finish_handshake();
        n_checks++;
        if (overflow8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky_idle: ovf=%b, required 1", overflow8);
        end
        $display("overflow: acc8=%0d ovf8=%b acc16=%0d", acc_out8, overflow8, acc_out);
    endtask

    task automatic test_zero_terms();
        drive_terms(0, 0);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || acc_out !== 16'd0 || overflow !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_hold: cycle=%0d out_valid=%b acc=%0d ovf=%b busy=%b, required 1 0 0 1",
                         k, out_valid, acc_out, overflow, busy);
            end
            if (k < 5) cyc();
        end
        finish_handshake();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        $display("zero_terms: acc=%0d", acc_out);
    endtask

    task automatic test_reset_mid();
        prods[0] = 90; prods[1] = 33;
        start = 1'b1; n_terms = 4'd4;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; product = 8'(prods[i]);
            cyc();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || acc_out !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b in_ready=%b acc=%0d, required 0 0 0", busy, in_ready, acc_out);
        end
        #2;
        rst = 1'b0;
        cyc();
        prods[0] = 7;
        drive_terms(1, 0);
        n_checks++;
        if (out_valid !== 1'b1 || acc_out !== 16'd7) begin
            n_fail++;
            $display("FAIL reset_fresh_run: out_valid=%b acc=%0d, required 1 7", out_valid, acc_out);
        end
        finish_handshake();
        $display("reset_mid: acc=%0d", acc_out);
    endtask

    task automatic test_start_ignored();
        prods[0] = 40; prods[1] = 50;
        start = 1'b1; n_terms = 4'd2;
        cyc();
        n_terms = 4'd9;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; product = 8'(prods[i]);
            cyc();
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || acc_out !== 16'd90) begin
            n_fail++;
            $display("FAIL start_in_accum: out_valid=%b acc=%0d, required 1 90", out_valid, acc_out);
        end
        out_ready = 1'b1;
        n_terms = 4'd3;
        cyc();
        out_ready = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || acc_out !== 16'd90) begin
            n_fail++;
            $display("FAIL start_in_done: busy=%b in_ready=%b acc=%0d, required 0 0 90", busy, in_ready, acc_out);
        end
        cyc();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done_after: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        $display("start_ignored: acc=%0d", acc_out);
    endtask

    task automatic test_random();
        longint e16, e8;
        bit     o16, o8;
        int     n, gap, hold;
        for (int r = 0; r < 24; r++) begin
            n    = int'($urandom_range(0, 15));
            gap  = int'($urandom_range(0, 2));
            hold = int'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) prods[i] = int'($urandom_range(0, 255));
            if (r % 4 == 0) for (int i = 0; i < 16; i++) prods[i] = int'($urandom_range(200, 255));
            model(n, 16, e16, o16);
            model(n, 8, e8, o8);
            drive_terms(n, gap);
            repeat (hold) cyc();
            n_checks++;
            if (out_valid !== 1'b1 || acc_out !== 16'(e16) || overflow !== o16) begin
                n_fail++;
                $display("FAIL rand16 run=%0d n=%0d: out_valid=%b acc=%0d ovf=%b, required 1 %0d %b",
                         r, n, out_valid, acc_out, overflow, e16, o16);
            end
            n_checks++;
            if (out_valid8 !== 1'b1 || acc_out8 !== 8'(e8) || overflow8 !== o8) begin
                n_fail++;
                $display("FAIL rand8 run=%0d n=%0d: out_valid=%b acc=%0d ovf=%b, required 1 %0d %b",
                         r, n, out_valid8, acc_out8, overflow8, e8, o8);
            end
            finish_handshake();
            $display("random run=%0d n=%0d gap=%0d acc16=%0d ovf16=%b acc8=%0d ovf8=%b",
                     r, n, gap, acc_out, overflow, acc_out8, overflow8);
        end
    endtask

    initial begin
        start     = 1'b0;
        n_terms   = 4'd0;
        in_valid  = 1'b0;
        product   = 8'd0;
        out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_overflow();
        test_zero_terms();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
